fdc_seek_ctrl: RTL and testbench
================================

# fdc_seek_ctrl

Host-side floppy seek controller: the initiator end of the 34-pin drive bus that our drive emulator responds to. It accepts seek and recalibrate commands from the host-side command logic. It then drives drive select, motor on, direction and step with the bus timing the drive expects, and uses track_0 and ready to maintain a tracked head position. It sits between the host command decoder and the bus pins, and is used to exercise the emulator in system tests.

## Interface
- DRIVE_NUM, 1: drive_sel bit asserted for this controller's drive.
- MAX_TRACK, 79: highest legal seek target.
- RECAL_MAX_STEPS, 85: step limit for recalibrate before error.
- DIR_SETUP_CYC, 8: minimum cycles from a dir_sel change to the step rising edge.
- STEP_PULSE_CYC, 4: step high width.
- STEP_RATE_CYC, 32: step period, rising edge to rising edge (> STEP_PULSE_CYC).
- SETTLE_CYC, 64: head settle time after the last step.
- SPINUP_TO_CYC, 1024: maximum wait for ready after motor_on.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd_op  in  1  0 = seek, 1 = recalibrate
- cmd_track  in  7  seek target (ignored for recalibrate)
- done  out  1  one-cycle completion pulse
- error  out  1  status qualified by done: 1 = command failed
- busy  out  1  command in progress
- cur_track  out  7  tracked head position
- drive_sel  out  4  bus drive select, active-high
- motor_on  out  1  bus motor on
- dir_sel  out  1  1 = step inward (track+1), 0 = outward
- step  out  1  bus step pulse, active-high
- track_0  in  1  bus track 00, active-high
- ready  in  1  bus drive ready

## Operation
- States: IDLE, SPINUP, DIR, STEP_HI, STEP_LO, SETTLE, FIN.
- IDLE: cmd_ready=1. Acceptance happens on cmd_valid & cmd_ready.
  - The command is latched on acceptance.
  - drive_sel[DRIVE_NUM] and motor_on go to 1 and remain 1 until the end of FIN.
  - Next state is SPINUP.
- SPINUP:
  - If ready=1, go to DIR.
  - If SPINUP_TO_CYC cycles elapse first, go to FIN with error.
- DIR:
  - Seek with cmd_track > MAX_TRACK: go to FIN with error. No step is issued.
  - Seek with cmd_track == cur_track: go to FIN directly. No step and no settle.
  - Seek otherwise: set dir_sel = (cmd_track > cur_track), wait DIR_SETUP_CYC, then go to STEP_HI.
  - Recalibrate: set dir_sel=0. If track_0=1, set cur_track=0 and go to FIN; otherwise wait DIR_SETUP_CYC, then go to STEP_HI.
- STEP_HI: step=1 for STEP_PULSE_CYC. On entry, cur_track moves ±1; a recalibrate step decrements with a floor of 0.
- STEP_LO: step=0 for STEP_RATE_CYC−STEP_PULSE_CYC cycles. At the end:
  - Seek: if the target is reached, go to SETTLE; else go to STEP_HI.
  - Recalibrate: if track_0=1, set cur_track=0 and go to SETTLE. If RECAL_MAX_STEPS have been issued, go to FIN with error. Otherwise go to STEP_HI.
- Outward seek mismatch: track_0=1 seen at the end of STEP_LO while cur_track≠0 sets cur_track=0 and goes to FIN with error.
- SETTLE: wait SETTLE_CYC, then go to FIN.
- FIN: done=1 and error valid for one cycle. Then drive_sel=0, motor_on=0, and return to IDLE.
- busy = !IDLE.

## Timing
- Reset: state IDLE, all outputs 0 except cmd_ready=1, cur_track=0, counters 0. Reset mid-step drops step in the next cycle.
- cmd_ready is combinational from state. cmd_valid during busy is ignored, not queued.
- Minimum latency for a no-step seek with ready already 1: accept, SPINUP (1 cycle), DIR (1 cycle), FIN pulse in the 3rd cycle after acceptance.
- The first step rising edge is ≥DIR_SETUP_CYC cycles after dir_sel is stable.
- Step period is exactly STEP_RATE_CYC. dir_sel never changes while step=1 or within a command.
- An N-step seek completes in SPINUP + 1 + DIR_SETUP_CYC + N·STEP_RATE_CYC + SETTLE_CYC + 1 cycles.
- All bus outputs are registered, so they are glitch-free.
- track_0 and ready are assumed synchronised upstream.

## Structure
- Shared package fdc_pkg holds:
  - state encodings
  - op codes (OP_SEEK, OP_RECAL)
  - direction constants (DIR_IN=1, DIR_OUT=0)
- Sub-module fdc_cyc_timer: a loadable down-counter with a zero flag. It is reused for spin-up, dir setup, step high/low and settle.

## Test plan
- Recalibrate from emulated track 5 → exactly 5 step pulses with dir_sel=0, then settle, done=1, error=0, cur_track=0.
- Seek from 0 to 3 → 3 pulses with dir_sel=1, edges 32 cycles apart, first edge ≥8 cycles after dir_sel changes, cur_track=3, done with error=0.
- Seek to the current track (3→3) → zero steps, done on the 3rd cycle after acceptance, error=0.
- Seek to 80 → no step, done with error=1, cur_track unchanged.
- ready held 0 → done with error=1 after 1024 spin-up cycles, with motor_on and drive_sel released.
- rst asserted during a 10-step seek → step=0 and all outputs at reset values the next cycle. The next recalibrate completes normally.

Source files
------------

// File: rtl/fdc_pkg.sv
// Shared types and constants for the floppy seek controller.
// States, op codes, step directions and counter widths.
package fdc_pkg;

  localparam int CYC_W   = 16;
  localparam int TRK_W   = 7;
  localparam int STEPS_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPINUP,
    ST_DIR,
    ST_STEP_HI,
    ST_STEP_LO,
    ST_SETTLE,
    ST_FIN
  } state_t;

  typedef enum logic {
    OP_SEEK  = 1'b0,
    OP_RECAL = 1'b1
  } op_t;

  localparam logic DIR_IN  = 1'b1;
  localparam logic DIR_OUT = 1'b0;

  // Timer load value that yields n cycles in the waiting state
  function automatic logic [CYC_W-1:0] cyc(input int n);
    return CYC_W'(n - 1);
  endfunction

endpackage

// File: rtl/fdc_cyc_timer.sv
// Loadable down-counter with a zero flag.
// Holds at zero until reloaded.
module fdc_cyc_timer
  import fdc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CYC_W-1:0] load_val,
  output logic             zero
);

  logic [CYC_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/fdc_seek_ctrl.sv
// Host-side floppy seek controller driving the 34-pin bus.
// Sequences spin-up, direction setup, stepping and settle.
module fdc_seek_ctrl
  import fdc_pkg::*;
#(
  parameter int DRIVE_NUM       = 1,
  parameter int MAX_TRACK       = 79,
  parameter int RECAL_MAX_STEPS = 85,
  parameter int DIR_SETUP_CYC   = 8,
  parameter int STEP_PULSE_CYC  = 4,
  parameter int STEP_RATE_CYC   = 32,
  parameter int SETTLE_CYC      = 64,
  parameter int SPINUP_TO_CYC   = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_op,
  input  logic [TRK_W-1:0] cmd_track,
  output logic             done,
  output logic             error,
  output logic             busy,
  output logic [TRK_W-1:0] cur_track,
  output logic [3:0]       drive_sel,
  output logic             motor_on,
  output logic             dir_sel,
  output logic             step,
  input  logic             track_0,
  input  logic             ready
);

  localparam logic [3:0] SEL_MASK = 4'(1) << DRIVE_NUM;

  state_t             state, state_n;
  op_t                op_q, op_n;
  logic [TRK_W-1:0]   tgt_q, tgt_n;
  logic [TRK_W-1:0]   trk_q, trk_n;
  logic [STEPS_W-1:0] nstep_q, nstep_n;
  logic               dir_q, dir_n;
  logic               err_q, err_n;
  logic               setup_q, setup_n;
  logic               ld;
  logic [CYC_W-1:0]   ld_val;
  logic               zero;
  logic               enter_hi;
  logic               enter_settle;
  logic [3:0]         sel_q;
  logic               motor_q;
  logic               step_q;

  fdc_cyc_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (ld),
    .load_val (ld_val),
    .zero     (zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      op_q    <= OP_SEEK;
      tgt_q   <= '0;
      trk_q   <= '0;
      nstep_q <= '0;
      dir_q   <= DIR_OUT;
      err_q   <= 1'b0;
      setup_q <= 1'b0;
      sel_q   <= '0;
      motor_q <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      state   <= state_n;
      op_q    <= op_n;
      tgt_q   <= tgt_n;
      trk_q   <= trk_n;
      nstep_q <= nstep_n;
      dir_q   <= dir_n;
      err_q   <= err_n;
      setup_q <= setup_n;
      sel_q   <= (state_n != ST_IDLE) ? SEL_MASK : '0;
      motor_q <= (state_n != ST_IDLE);
      step_q  <= (state_n == ST_STEP_HI);
    end
  end

  always_comb begin
    state_n = state;
    op_n    = op_q;
    tgt_n   = tgt_q;
    trk_n   = trk_q;
    nstep_n = nstep_q;
    dir_n   = dir_q;
    err_n   = err_q;
    setup_n = setup_q;
    ld      = 1'b0;
    ld_val  = '0;
    unique case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_n = ST_SPINUP;
          op_n    = op_t'(cmd_op);
          tgt_n   = cmd_track;
          err_n   = 1'b0;
          setup_n = 1'b0;
          nstep_n = '0;
          ld      = 1'b1;
          ld_val  = cyc(SPINUP_TO_CYC);
        end
      end
      ST_SPINUP: begin
        if (ready) begin
          state_n = ST_DIR;
        end else if (zero) begin
          state_n = ST_FIN;
          err_n   = 1'b1;
        end
      end
      ST_DIR: begin
        if (setup_q) begin
          if (zero)
            state_n = ST_STEP_HI;
        end else if (op_q == OP_RECAL) begin
          dir_n = DIR_OUT;
          if (track_0) begin
            trk_n   = '0;
            state_n = ST_FIN;
          end else begin
            setup_n = 1'b1;
            ld      = 1'b1;
            ld_val  = cyc(DIR_SETUP_CYC);
          end
        end else if (tgt_q > TRK_W'(MAX_TRACK)) begin
          err_n   = 1'b1;
          state_n = ST_FIN;
        end else if (tgt_q == trk_q) begin
          state_n = ST_FIN;
        end else begin
          dir_n   = (tgt_q > trk_q) ? DIR_IN : DIR_OUT;
          setup_n = 1'b1;
          ld      = 1'b1;
          ld_val  = cyc(DIR_SETUP_CYC);
        end
      end
      ST_STEP_HI: begin
        if (zero) begin
          state_n = ST_STEP_LO;
          ld      = 1'b1;
          ld_val  = cyc(STEP_RATE_CYC - STEP_PULSE_CYC);
        end
      end
      ST_STEP_LO: begin
        if (zero) begin
          if (op_q == OP_RECAL) begin
            if (track_0) begin
              trk_n   = '0;
              state_n = ST_SETTLE;
            end else if (nstep_q == STEPS_W'(RECAL_MAX_STEPS)) begin
              err_n   = 1'b1;
              state_n = ST_FIN;
            end else begin
              state_n = ST_STEP_HI;
            end
          end else if (dir_q == DIR_OUT && track_0 && trk_q != '0) begin
            // Drive reports track 00 before our count does: resync
            trk_n   = '0;
            err_n   = 1'b1;
            state_n = ST_FIN;
          end else if (trk_q == tgt_q) begin
            state_n = ST_SETTLE;
          end else begin
            state_n = ST_STEP_HI;
          end
        end
      end
      ST_SETTLE: begin
        if (zero)
          state_n = ST_FIN;
      end
      ST_FIN: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    enter_hi     = (state_n == ST_STEP_HI) && (state != ST_STEP_HI);
    enter_settle = (state_n == ST_SETTLE) && (state != ST_SETTLE);
    unique case (1'b1)
      enter_hi: begin
        ld      = 1'b1;
        ld_val  = cyc(STEP_PULSE_CYC);
        nstep_n = nstep_q + 1'b1;
        if (op_q == OP_RECAL)
          trk_n = (trk_q == '0) ? '0 : trk_q - 1'b1;
        else if (dir_q == DIR_IN)
          trk_n = trk_q + 1'b1;
        else
          trk_n = trk_q - 1'b1;
      end
      enter_settle: begin
        ld     = 1'b1;
        ld_val = cyc(SETTLE_CYC);
      end
      default: begin
      end
    endcase
  end

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_FIN);
  assign error     = done & err_q;
  assign cur_track = trk_q;
  assign drive_sel = sel_q;
  assign motor_on  = motor_q;
  assign step      = step_q;
  assign dir_sel   = dir_q;

endmodule

// File: tb/tb_fdc_seek_ctrl.sv
// Directed bench for fdc_seek_ctrl with a drive head emulator
// and a scoreboard of expected command results.
module tb_fdc_seek_ctrl;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_op;
  logic [6:0] cmd_track;
  logic       done;
  logic       error;
  logic       busy;
  logic [6:0] cur_track;
  logic [3:0] drive_sel;
  logic       motor_on;
  logic       dir_sel;
  logic       step;
  logic       track_0;
  logic       ready;

  typedef struct {
    logic       err;
    logic [6:0] trk;
    int         steps;
    int         lat;
  } exp_t;

  exp_t sb[$];

  int   ntests = 0;
  int   nfail  = 0;
  int   cyc    = 0;
  int   pos    = 0;
  logic ready_en;

  int   npulse     = 0;
  int   last_edge  = 0;
  int   first_edge = 0;
  int   dir_chg    = 0;
  logic step_prev  = 1'b0;
  logic dir_prev   = 1'b0;
  logic exp_dir    = 1'b0;
  logic ivl_bad    = 1'b0;
  logic dir_bad    = 1'b0;
  int   p0         = 0;

  assign track_0 = (pos == 0);
  assign ready   = ready_en & motor_on;

  fdc_seek_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_track (cmd_track),
    .done      (done),
    .error     (error),
    .busy      (busy),
    .cur_track (cur_track),
    .drive_sel (drive_sel),
    .motor_on  (motor_on),
    .dir_sel   (dir_sel),
    .step      (step),
    .track_0   (track_0),
    .ready     (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One cycle; samples at negedge and runs the head emulator
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (step && !step_prev) begin
      npulse++;
      if (npulse - p0 > 1) begin
        if (cyc - last_edge != 32)
          ivl_bad = 1'b1;
      end else begin
        first_edge = cyc;
      end
      last_edge = cyc;
      if (dir_sel !== exp_dir)
        dir_bad = 1'b1;
      if (dir_sel)
        pos = pos + 1;
      else if (pos > 0)
        pos = pos - 1;
    end
    if (dir_sel !== dir_prev)
      dir_chg = cyc;
    dir_prev  = dir_sel;
    step_prev = step;
  endtask

  task automatic issue(input logic op, input logic [6:0] trk,
                       input logic edir, output int acc);
    p0        = npulse;
    ivl_bad   = 1'b0;
    dir_bad   = 1'b0;
    exp_dir   = edir;
    cmd_op    = op;
    cmd_track = trk;
    cmd_valid = 1'b1;
    acc       = cyc;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input string tag, input logic op,
                         input logic [6:0] trk, input logic edir,
                         input logic e_err, input logic [6:0] e_trk,
                         input int e_steps, input int e_lat);
    exp_t e;
    int   acc;
    int   n;
    sb.push_back('{err: e_err, trk: e_trk, steps: e_steps, lat: e_lat});
    issue(op, trk, edir, acc);
    n = 0;
    while (done !== 1'b1 && n < 5000) begin
      tick();
      n++;
    end
    check({tag, "_done"}, int'(done), 1);
    e = sb.pop_front();
    if (done === 1'b1) begin
      check({tag, "_err"}, int'(error), int'(e.err));
      check({tag, "_trk"}, int'(cur_track), int'(e.trk));
      check({tag, "_steps"}, npulse - p0, e.steps);
      check({tag, "_lat"}, cyc - acc, e.lat);
      if (e.steps > 1)
        check({tag, "_period"}, int'(ivl_bad), 0);
      if (e.steps > 0)
        check({tag, "_dir"}, int'(dir_bad), 0);
      tick();
      check({tag, "_rel_sel"}, int'(drive_sel), 0);
      check({tag, "_rel_motor"}, int'(motor_on), 0);
      check({tag, "_idle"}, int'(cmd_ready), 1);
    end
  endtask

  initial begin
    int acc;
    int n;
    int k;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 1'b0;
    cmd_track = '0;
    ready_en  = 1'b1;
    pos       = 0;
    repeat (3) tick();

    check("rst_cmd_ready", int'(cmd_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_step", int'(step), 0);
    check("rst_sel", int'(drive_sel), 0);
    check("rst_motor", int'(motor_on), 0);
    check("rst_dir", int'(dir_sel), 0);
    check("rst_trk", int'(cur_track), 0);
    check("rst_done", int'(done), 0);
    rst = 1'b0;
    tick();

    pos = 5;
    run_cmd("recal5", 1'b1, 7'd0, 1'b0, 1'b0, 7'd0, 5, 75 + 32 * 5);
    check("recal5_head", pos, 0);

    run_cmd("seek3", 1'b0, 7'd3, 1'b1, 1'b0, 7'd3, 3, 75 + 32 * 3);
    check("seek3_setup", int'(first_edge - dir_chg >= 8), 1);
    check("seek3_head", pos, 3);

    run_cmd("same3", 1'b0, 7'd3, 1'b1, 1'b0, 7'd3, 0, 3);
    run_cmd("seek80", 1'b0, 7'd80, 1'b1, 1'b1, 7'd3, 0, 3);

    ready_en = 1'b0;
    run_cmd("spinto", 1'b0, 7'd5, 1'b1, 1'b1, 7'd3, 0, 1 + 1024);
    ready_en = 1'b1;

    issue(1'b0, 7'd13, 1'b1, acc);
    check("busy_on", int'(busy), 1);
    n = 0;
    while (npulse - p0 < 3 && n < 2000) begin
      tick();
      n++;
    end
    check("mid_pulses", npulse - p0, 3);
    check("mid_step_hi", int'(step), 1);
    rst = 1'b1;
    tick();
    check("mrst_step", int'(step), 0);
    check("mrst_sel", int'(drive_sel), 0);
    check("mrst_motor", int'(motor_on), 0);
    check("mrst_dir", int'(dir_sel), 0);
    check("mrst_trk", int'(cur_track), 0);
    check("mrst_busy", int'(busy), 0);
    check("mrst_ready", int'(cmd_ready), 1);
    rst = 1'b0;
    tick();

    k = pos;
    check("mrst_head", k, 6);
    run_cmd("recal_after", 1'b1, 7'd0, 1'b0, 1'b0, 7'd0, k, 75 + 32 * k);
    check("recal_after_head", pos, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
